// File: rtl/apb_memif_bridge.sv
// APB4 completer bridging each transfer to one memory-interface request.
// Ports: clk_i/arst_ni, APB p*_i/p*_o, memory m*_o/m*_i.
module apb_memif_bridge #(
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    arst_ni,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic [ADDR_WIDTH-1:0]   paddr_i,
  input  logic                    pwrite_i,
  input  logic [DATA_WIDTH-1:0]   pwdata_i,
  input  logic [DATA_WIDTH/8-1:0] pstrb_i,
  output logic                    pready_o,
  output logic [DATA_WIDTH-1:0]   prdata_o,
  output logic                    pslverr_o,
  output logic                    mreq_o,
  output logic [ADDR_WIDTH-1:0]   maddr_o,
  output logic                    mwe_o,
  output logic [DATA_WIDTH-1:0]   mwdata_o,
  output logic [DATA_WIDTH/8-1:0] mstrb_o,
  input  logic                    mack_i,
  input  logic [DATA_WIDTH-1:0]   mrdata_i,
  input  logic                    mresp_i
);

  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam int unsigned CW =
    (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TO_M1 =
    (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TO_M1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [SW-1:0]         strb_q, strb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  to_hit;

  assign to_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (psel_i && !penable_i) begin
          addr_d  = paddr_i;
          we_d    = pwrite_i;
          wdata_d = pwdata_i;
          strb_d  = pwrite_i ? pstrb_i : '1;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
        // A vanished master cannot take a response.
        if (!psel_i) begin
          state_d = IDLE;
        end else if (mack_i) begin
          rdata_d = we_q ? '0 : mrdata_i;
          err_d   = mresp_i;
          state_d = DONE;
        end else if (to_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mreq_o    = (state_q == REQ);
  assign pready_o  = (state_q == DONE);
  assign prdata_o  = rdata_q;
  assign pslverr_o = err_q;
  assign maddr_o   = addr_q;
  assign mwe_o     = we_q;
  assign mwdata_o  = wdata_q;
  assign mstrb_o   = strb_q;

endmodule

// File: tb/tb_apb_memif_bridge.sv
// Randomized bench for apb_memif_bridge against a memory/APB model.
// Drives and samples on the falling clock edge.
module tb_apb_memif_bridge;

  logic        clk;
  logic        arst_n;
  logic        psel;
  logic        penable;
  logic [4:0]  paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        mreq;
  logic [4:0]  maddr;
  logic        mwe;
  logic [31:0] mwdata;
  logic [3:0]  mstrb;
  logic        mack;
  logic [31:0] mrdata;
  logic        mresp;

  int n_chk;
  int n_err;
  logic [31:0] mem [32];

  apb_memif_bridge #(
    .ADDR_WIDTH(5),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk),
    .arst_ni(arst_n),
    .psel_i(psel),
    .penable_i(penable),
    .paddr_i(paddr),
    .pwrite_i(pwrite),
    .pwdata_i(pwdata),
    .pstrb_i(pstrb),
    .pready_o(pready),
    .prdata_o(prdata),
    .pslverr_o(pslverr),
    .mreq_o(mreq),
    .maddr_o(maddr),
    .mwe_o(mwe),
    .mwdata_o(mwdata),
    .mstrb_o(mstrb),
    .mack_i(mack),
    .mrdata_i(mrdata),
    .mresp_i(mresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic bit valid(input logic [4:0] a);
    return a < 5'd24;
  endfunction

  function automatic logic [31:0] smask(input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{s[i]}};
    return m;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pready"}, 32'(pready), 0);
    chk({tag, "_prdata"}, prdata, 0);
    chk({tag, "_pslverr"}, 32'(pslverr), 0);
    chk({tag, "_mreq"}, 32'(mreq), 0);
    chk({tag, "_maddr"}, 32'(maddr), 0);
    chk({tag, "_mwe"}, 32'(mwe), 0);
    chk({tag, "_mwdata"}, mwdata, 0);
    chk({tag, "_mstrb"}, 32'(mstrb), 0);
  endtask

  // Called at a falling edge; dly < 0 means the memory never acks.
  task automatic xfer(input logic [4:0] a, input logic w,
                      input logic [31:0] wd, input logic [3:0] sb,
                      input int dly, input logic ferr);
    logic [3:0]  es;
    logic [31:0] exp_d;
    logic        exp_e;
    logic [31:0] rd;
    logic        er;
    int          nreq;
    int          exp_n;
    bit          got;
    es = w ? sb : 4'hF;
    rd = '0;
    er = 1'b0;
    nreq = 0;
    got = 0;
    psel = 1'b1;
    penable = 1'b0;
    paddr = a;
    pwrite = w;
    pwdata = wd;
    pstrb = sb;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge clk);
      penable = 1'b1;
      mack = 1'b0;
      mresp = 1'b0;
      mrdata = '0;
      if (pready) begin
        got = 1;
        rd = prdata;
        er = pslverr;
      end else if (mreq) begin
        nreq++;
        chk("maddr", 32'(maddr), 32'(a));
        chk("mwe", 32'(mwe), 32'(w));
        chk("mstrb", 32'(mstrb), 32'(es));
        if (w) chk("mwdata", mwdata, wd);
        if (nreq == dly + 1) begin
          mack = 1'b1;
          mresp = ferr | !valid(a);
          if (w) mrdata = $urandom;
          else mrdata = valid(a) ? mem[a] : 32'h0;
        end
      end
    end
    chk("done", 32'(got), 1);
    if (dly < 0) begin
      exp_n = 16;
      exp_e = 1'b1;
      exp_d = '0;
    end else begin
      exp_n = dly + 1;
      exp_e = ferr | !valid(a);
      exp_d = (!w && valid(a)) ? mem[a] : 32'h0;
      if (w && !exp_e) mem[a] = (mem[a] & ~smask(sb)) | (wd & smask(sb));
    end
    chk("nreq", nreq, exp_n);
    chk("prdata", rd, exp_d);
    chk("pslverr", 32'(er), 32'(exp_e));
    @(negedge clk);
    psel = 1'b0;
    penable = 1'b0;
    mack = 1'b0;
    mresp = 1'b0;
    chk("post_pready", 32'(pready), 0);
    chk("post_prdata", prdata, 0);
    chk("post_pslverr", 32'(pslverr), 0);
    chk("post_mreq", 32'(mreq), 0);
  endtask

  task automatic abort_xfer(input logic [4:0] a, input int k);
    psel = 1'b1;
    penable = 1'b0;
    paddr = a;
    pwrite = 1'b0;
    pwdata = $urandom;
    pstrb = 4'h0;
    repeat (k) begin
      @(negedge clk);
      penable = 1'b1;
      chk("ab_mreq", 32'(mreq), 1);
    end
    @(negedge clk);
    psel = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    chk("ab_mreq_drop", 32'(mreq), 0);
    chk("ab_pready", 32'(pready), 0);
    @(negedge clk);
    chk("ab_pready2", 32'(pready), 0);
  endtask

  initial begin
    int dly;
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    arst_n = 1'b0;
    psel = 1'b0;
    penable = 1'b0;
    paddr = '0;
    pwrite = 1'b0;
    pwdata = '0;
    pstrb = '0;
    mack = 1'b0;
    mrdata = '0;
    mresp = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    arst_n = 1'b1;
    @(negedge clk);

    xfer(5'h04, 1'b1, 32'h0000_2580, 4'hF, 0, 1'b0);
    xfer(5'h08, 1'b1, 32'h0000_00A5, 4'hF, 1, 1'b0);
    xfer(5'h08, 1'b0, 32'h0, 4'h0, 3, 1'b0);
    xfer(5'h04, 1'b1, 32'h1234_5678, 4'h5, 0, 1'b0);
    xfer(5'h04, 1'b0, 32'h0, 4'h0, 0, 1'b0);
    xfer(5'h0C, 1'b1, 32'hDEAD_BEEF, 4'hF, 2, 1'b1);
    xfer(5'h1C, 1'b0, 32'h0, 4'h0, 1, 1'b0);
    xfer(5'h10, 1'b0, 32'h0, 4'h0, -1, 1'b0);
    abort_xfer(5'h08, 3);
    xfer(5'h08, 1'b0, 32'h0, 4'h0, 0, 1'b0);

    xfer(5'h04, 1'b0, 32'h0, 4'h0, 0, 1'b0);
    xfer(5'h08, 1'b0, 32'h0, 4'h0, 1, 1'b0);
    psel = 1'b1;
    penable = 1'b0;
    paddr = 5'h08;
    pwrite = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    chk("rst_pre_mreq", 32'(mreq), 1);
    #2 arst_n = 1'b0;
    #1 chk_all_zero("arst");
    @(negedge clk);
    psel = 1'b0;
    penable = 1'b0;
    arst_n = 1'b1;
    @(negedge clk);
    chk("arst_idle_mreq", 32'(mreq), 0);
    xfer(5'h08, 1'b0, 32'h0, 4'h0, 0, 1'b0);

    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        abort_xfer(5'($urandom_range(0, 31)), int'($urandom_range(1, 10)));
      end else begin
        dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
        xfer(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             $urandom, 4'($urandom_range(0, 15)), dly,
             ($urandom_range(0, 7) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
